fxy_response_checker: RTL and testbench

Response-side counterpart to the two-input `fxy` stimulus sweep. It accepts sampled `(x, y, s1, s2)` tuples over a valid/ready handshake and compares the DUT outputs against the golden function `s1 = s2 = ~x & y`. It counts samples and mismatches, tracks coverage of the four input combinations, and reports done/pass once every combination has been seen. It sits between a DUT wrapper and the bench, replacing visual `$monitor` inspection with a self-checking verdict.

---
 rtl/fxy_response_checker.sv | 110 +++++++++++
 tb/tb_fxy_response_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxy_response_checker.sv
// Self-checking response checker for the two-input fxy sweep (golden s1 = s2 = ~x & y).
// Define FXY_FIRST_FAIL_EN to add the first_fail capture register and port.
module fxy_response_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic             y,
    input  logic             s1,
    input  logic             s2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [3:0]       covered
`ifdef FXY_FIRST_FAIL_EN
    ,
    output logic [3:0]       first_fail
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_next;
    logic [1:0] idx;
    logic       expected;
    logic       mismatch;
    logic       accept;
    logic [3:0] covered_next;

    // start takes precedence over a simultaneous handshake, discarding the sample
    always_comb begin
        idx          = {x, y};
        expected     = ~x & y;
        mismatch     = (s1 != expected) || (s2 != expected);
        accept       = in_valid & in_ready & ~start;
        covered_next = covered | (4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (start) begin
                    state_next = RUN;
                end else if (accept && (covered_next == 4'b1111)) begin
                    state_next = DONE;
                end
            end
            DONE: if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN);
        done     = (state == DONE);
        pass     = (state == DONE) && (mismatch_cnt == '0);
    end

    // Counters saturate so a long faulty run can never wrap back to a clean-looking zero
    always_ff @(posedge clk) begin
        if (rst || start) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            covered      <= '0;
        end else if (accept) begin
            covered <= covered_next;
            if (sample_cnt != CNT_MAX) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (mismatch && (mismatch_cnt != CNT_MAX)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

`ifdef FXY_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            first_fail <= '0;
        end else if (accept && mismatch && (mismatch_cnt == '0)) begin
            first_fail <= {x, y, s1, s2};
        end
    end
`endif

endmodule

// File: tb/tb_fxy_response_checker.sv
// Scoreboard bench for fxy_response_checker: a behavioural model predicts the outputs after every
// accepted sample and a monitor compares them when the handshake fires (FXY_FIRST_FAIL_EN aware).
module tb_fxy_response_checker;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             y;
    logic             s1;
    logic             s2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [3:0]       covered;
`ifdef FXY_FIRST_FAIL_EN
    logic [3:0]       first_fail;
`endif

    fxy_response_checker #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .s1           (s1),
        .s2           (s2),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .covered      (covered)
`ifdef FXY_FIRST_FAIL_EN
        ,
        .first_fail   (first_fail)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         samples;
        int         mismatches;
        logic [3:0] cov;
        bit         is_done;
        bit         is_pass;
        logic [3:0] first;
    } exp_t;

    exp_t       exp_q[$];
    int         m_samples;
    int         m_mismatches;
    bit         m_seen[4];
    bit         m_run;
    bit         m_done;
    logic [3:0] m_first;
    int         n_checks = 0;
    int         n_fails  = 0;
    bit         hs_seen  = 1'b0;

    function automatic logic [3:0] model_cov();
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = m_seen[i];
        return c;
    endfunction

    function automatic void model_clear(bit run);
        m_samples    = 0;
        m_mismatches = 0;
        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        m_run   = run;
        m_done  = 1'b0;
        m_first = 4'b0000;
    endfunction

    // A sample counts only while running; coverage completion ends the run
    function automatic void model_accept(bit xv, bit yv, bit s1v, bit s2v);
        bit   golden;
        exp_t e;
        if (!m_run) return;
        golden = !xv && yv;
        if (m_samples < CNT_MAX) m_samples++;
        if (s1v != golden || s2v != golden) begin
            if (m_mismatches == 0) m_first = {xv, yv, s1v, s2v};
            if (m_mismatches < CNT_MAX) m_mismatches++;
        end
        m_seen[{xv, yv}] = 1'b1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end
        e.samples    = m_samples;
        e.mismatches = m_mismatches;
        e.cov        = model_cov();
        e.is_done    = m_done;
        e.is_pass    = m_done && (m_mismatches == 0);
        e.first      = m_first;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_run));
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(m_run));
        checkOutput({tag, ".done"}, 32'(done), 32'(m_done));
        checkOutput({tag, ".pass"}, 32'(pass), 32'(m_done && m_mismatches == 0));
        checkOutput({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(m_samples));
        checkOutput({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mismatches));
        checkOutput({tag, ".covered"}, 32'(covered), 32'(model_cov()));
`ifdef FXY_FIRST_FAIL_EN
        checkOutput({tag, ".first_fail"}, 32'(first_fail), 32'(m_first));
`endif
    endtask

    // Drive one tuple for one cycle; with_start also pulses start in the same cycle
    task automatic applyStimulus(input bit xv, input bit yv, input bit s1v, input bit s2v, input bit with_start);
        x        = xv;
        y        = yv;
        s1       = s1v;
        s2       = s2v;
        in_valid = 1'b1;
        start    = with_start;
        if (with_start) model_clear(1'b1);
        else model_accept(xv, yv, s1v, s2v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        model_clear(1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_good(input bit xv, input bit yv);
        applyStimulus(xv, yv, !xv && yv, !xv && yv, 1'b0);
    endtask

    always @(posedge clk) hs_seen <= in_valid && in_ready && !start && !rst;

    always @(negedge clk) begin
        if (hs_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_accept: got accept, expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("mon.sample_cnt", 32'(sample_cnt), 32'(e.samples));
                checkOutput("mon.mismatch_cnt", 32'(mismatch_cnt), 32'(e.mismatches));
                checkOutput("mon.covered", 32'(covered), 32'(e.cov));
                checkOutput("mon.done", 32'(done), 32'(e.is_done));
                checkOutput("mon.pass", 32'(pass), 32'(e.is_pass));
`ifdef FXY_FIRST_FAIL_EN
                checkOutput("mon.first_fail", 32'(first_fail), 32'(e.first));
`endif
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        x        = 1'b0;
        y        = 1'b0;
        s1       = 1'b0;
        s2       = 1'b0;
        model_clear(1'b0);
        idle_cycles(2);
        rst = 1'b0;
        checkState("reset");

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkState("idle_ignores");

        do_start();
        checkState("after_start");
        send_good(0, 0);
        send_good(0, 1);
        send_good(1, 0);
        send_good(1, 1);
        checkState("clean_sweep");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("done_holds");

        do_start();
        send_good(0, 0);
        send_good(0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_good(1, 1);
        checkState("bad_sweep");

        do_start();
        begin
            bit [1:0] order[6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10};
            for (int i = 0; i < 6; i++) begin
                idle_cycles($urandom_range(0, 3));
                send_good(order[i][1], order[i][0]);
                checkState($sformatf("order_%0d", i));
            end
        end

        do_start();
        send_good(0, 0);
        send_good(1, 1);
        do_reset();
        checkState("mid_run_reset");

        do_start();
        send_good(0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkState("start_beats_accept_run");
        send_good(0, 0);
        send_good(0, 1);
        send_good(1, 0);
        send_good(1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkState("start_in_done");

        do_start();
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_good(0, 0);
        send_good(1, 0);
        send_good(1, 1);
        checkState("saturation");

        for (int run = 0; run < 20; run++) begin
            do_start();
            for (int i = 0; i < 40; i++) begin
                bit xv = 1'($urandom_range(0, 1));
                bit yv = 1'($urandom_range(0, 1));
                bit g  = !xv && yv;
                bit e1 = ($urandom_range(0, 7) == 0);
                bit e2 = ($urandom_range(0, 7) == 0);
                idle_cycles($urandom_range(0, 2));
                applyStimulus(xv, yv, g ^ e1, g ^ e2, ($urandom_range(0, 49) == 0));
            end
            checkState($sformatf("random_run_%0d", run));
        end

        idle_cycles(2);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
